// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end sharing one registered N-bit adder/subtractor.
// Optional overflow saturation of the result when ADDSUB_ARB_SAT_EN is defined.
module addsub_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_z,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic         rsp_id,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic           prio_q;
  logic [N-1:0]   x_q;
  logic [N-1:0]   y_q;
  logic           sub_q;
  logic           id_q;
  logic           rsp_valid_q;
  logic [N-1:0]   rsp_z_q;
  logic           rsp_c_q;
  logic           rsp_v_q;
  logic           rsp_id_q;

  logic           idle;
  logic           any_valid;
  logic           gnt_id;
  logic [N-1:0]   yc;
  logic [N:0]     sum;
  logic           ovf_d;
  logic [N-1:0]   z_d;

  // Grant is only meaningful in IDLE; the pointer breaks ties between two valid requesters.
  always_comb begin
    idle       = (state_q == IDLE);
    any_valid  = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? prio_q : req1_valid;
    req0_ready = idle & req0_valid & ~gnt_id;
    req1_ready = idle & req1_valid &  gnt_id;
  end

  always_comb begin
    yc    = y_q ^ {N{sub_q}};
    sum   = {1'b0, x_q} + {1'b0, yc} + {{N{1'b0}}, sub_q};
    ovf_d = (x_q[N-1] == yc[N-1]) & (sum[N-1] != x_q[N-1]);
`ifdef ADDSUB_ARB_SAT_EN
    if (ovf_d) begin
      z_d = x_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      z_d = sum[N-1:0];
    end
`else
    z_d = sum[N-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            x_q     <= gnt_id ? req1_x   : req0_x;
            y_q     <= gnt_id ? req1_y   : req0_y;
            sub_q   <= gnt_id ? req1_sub : req0_sub;
            id_q    <= gnt_id;
            prio_q  <= ~gnt_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_z_q     <= z_d;
          rsp_c_q     <= sum[N];
          rsp_v_q     <= ovf_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: scoreboard of expected responses, reset, fairness, backpressure.
module tb_addsub_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [N-1:0] req0_x, req0_y;
  logic         req1_valid, req1_ready, req1_sub;
  logic [N-1:0] req1_x, req1_y;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_z;
  logic         rsp_c, rsp_v, rsp_id, busy;

  addsub_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] z;
    logic       c;
    logic       v;
    logic       id;
  } exp_t;

  exp_t sb[$];
  int   gnt_id_log[$];
  int   gnt_cyc_log[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  function automatic exp_t model(logic id, logic [7:0] x, logic [7:0] y, logic sub);
    exp_t e;
    int ux = int'(x);
    int uy = int'(y);
    int sx = x[7] ? ux - 256 : ux;
    int sy = y[7] ? uy - 256 : uy;
    int sr;
    if (sub) begin
      e.z = 8'((ux - uy + 256) % 256);
      e.c = (ux >= uy);
      sr  = sx - sy;
    end else begin
      e.z = 8'((ux + uy) % 256);
      e.c = (ux + uy) > 255;
      sr  = sx + sy;
    end
    e.v  = (sr > 127) || (sr < -128);
`ifdef ADDSUB_ARB_SAT_EN
    if (e.v) e.z = (sx >= 0) ? 8'h7F : 8'h80;
`endif
    e.id = id;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: push on acceptance, pop and compare on response transfer.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        sb.push_back(model(1'b0, req0_x, req0_y, req0_sub));
        gnt_id_log.push_back(0);
        gnt_cyc_log.push_back(cyc);
        $display("accept  req0 x=%02h y=%02h sub=%0b", req0_x, req0_y, req0_sub);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1'b1, req1_x, req1_y, req1_sub));
        gnt_id_log.push_back(1);
        gnt_cyc_log.push_back(cyc);
        $display("accept  req1 x=%02h y=%02h sub=%0b", req1_x, req1_y, req1_sub);
      end
      check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        compared++;
        assert (sb.size() > 0) else begin
          mismatched++;
          $error("FAIL rsp_unexpected: observed response z=%02h with empty scoreboard, required none", rsp_z);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("respond id=%0d z=%02h c=%0b v=%0b (exp z=%02h c=%0b v=%0b)",
                   rsp_id, rsp_z, rsp_c, rsp_v, e.z, e.c, e.v);
          check("rsp_z", {24'd0, rsp_z}, {24'd0, e.z});
          check("rsp_c", {31'd0, rsp_c}, {31'd0, e.c});
          check("rsp_v", {31'd0, rsp_v}, {31'd0, e.v});
          check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic k, input logic [7:0] x, input logic [7:0] y, input logic sub);
    bit ok = 0;
    drive_at_edge();
    if (k == 1'b0) begin
      req0_valid = 1'b1; req0_x = x; req0_y = y; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_x = x; req1_y = y; req1_sub = sub;
    end
    for (int i = 0; i < 20; i++) begin
      sample();
      if ((k == 1'b0 && req0_ready) || (k == 1'b1 && req1_ready)) begin
        ok = 1;
        break;
      end
    end
    check("send_accept_timeout", {31'd0, ok}, 32'd1);
    drive_at_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!busy && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [7:0] tk [7];
    logic [7:0] tx [7];
    logic [7:0] ty [7];
    logic [7:0] ts [7];
    exp_t e_bp;
    bit   won0;
    bit   found;

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_sub = 1'b0;
    repeat (3) sample();
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rsp_z", {24'd0, rsp_z}, 32'd0);
    rst_n = 1'b1;

    // Add with latency check: EXEC one cycle after acceptance, response the next.
    send(1'b0, 8'h05, 8'h03, 1'b0);
    sample();
    check("lat_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("lat_exec_busy", {31'd0, busy}, 32'd1);
    sample();
    check("lat_resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // Directed arithmetic table: subtract, borrow, both overflow directions, wrap.
    tk = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    tx = '{8'h05, 8'h03, 8'h7F, 8'h80, 8'hFF, 8'h80, 8'h00};
    ty = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01, 8'h80, 8'h01};
    ts = '{8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 7; i++) begin
      send(tk[i][0], tx[i], ty[i], ts[i][0]);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      send(1'(i), 8'($urandom), 8'($urandom), 1'($urandom));
      wait_idle();
    end
    check("sb_drained", sb.size(), 32'd0);

    // Asynchronous reset in the middle of RESP discards the operation.
    rsp_ready = 1'b0;
    send(1'b1, 8'h12, 8'h34, 1'b0);
    sample();
    sample();
    check("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_rsp_z", {24'd0, rsp_z}, 32'd0);
    check("async_rst_rsp_c", {31'd0, rsp_c}, 32'd0);
    check("async_rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("async_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    sb.delete();
    gnt_id_log.delete();
    gnt_cyc_log.delete();
    sample();
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Fairness: both held valid, grants 0,1,0,1 spaced 3 cycles apart.
    drive_at_edge();
    req0_valid = 1'b1; req0_x = 8'h10; req0_y = 8'h20; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_x = 8'h40; req1_y = 8'h05; req1_sub = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (gnt_id_log.size() >= 4) begin
        found = 1;
        break;
      end
    end
    check("fair_grant_timeout", {31'd0, found}, 32'd1);
    drive_at_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("fair_grant_count", gnt_id_log.size(), 32'd4);
    if (gnt_id_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("fair_grant_%0d", i), gnt_id_log[i], i % 2);
        if (i > 0) check($sformatf("fair_spacing_%0d", i), gnt_cyc_log[i] - gnt_cyc_log[i-1], 32'd3);
      end
    end

    // Backpressure: five RESP cycles with rsp_ready low, loser then cancels.
    gnt_id_log.delete();
    drive_at_edge();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 8'h22; req0_y = 8'h11; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_x = 8'h33; req1_y = 8'h44; req1_sub = 1'b1;
    sample();
    won0 = req0_ready;
    check("bp_winner_req0", {31'd0, req0_ready}, 32'd1);
    e_bp = won0 ? model(1'b0, 8'h22, 8'h11, 1'b0) : model(1'b1, 8'h33, 8'h44, 1'b1);
    sample();
    check("bp_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_z", {24'd0, rsp_z}, {24'd0, e_bp.z});
      check("bp_rsp_id", {31'd0, rsp_id}, {31'd0, e_bp.id});
      check("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    drive_at_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) begin
      sample();
      check("cancel_no_busy", {31'd0, busy}, 32'd0);
    end
    check("cancel_grants", gnt_id_log.size(), 32'd1);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
